// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores fill a byte FIFO, a serialiser drains it onto tx.
// Latency: a store into an empty FIFO with the line idle pops one edge later; the start bit follows that pop edge.
// Backpressure: none to the core; a push to a full FIFO is dropped and latches a sticky overflow flag (W1C via STATUS[3]).
`timescale 1ns/1ps

module uart_tx_mmio #(
  parameter int          CLKS_PER_BIT = 434,
  parameter int          FIFO_DEPTH   = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_2000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] Mem_WrAddr,
  input  logic [31:0] Mem_WrData,
  output logic [31:0] ReadData,
  output logic        hit,
  output logic        tx,
  output logic        tx_busy
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [31:0]       STATUS_ADDR = BASE_ADDR + 32'd4;
  localparam logic [BAUD_W-1:0] BAUD_LAST   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_e;

  // Address decode: word address only, byte offset ignored
  logic hit_txdata;
  logic hit_status;

  // FIFO storage and bookkeeping
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  logic push_req;
  logic push;
  logic pop;
  logic fifo_empty;
  logic fifo_full;

  // Serialiser state
  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              tx_q, tx_d;
  logic              baud_done;

  // Count as seen through the 8-bit STATUS field; a 256-deep full FIFO reads back 0 here but full=1
  logic [7:0] status_cnt;

  // Store-data and address bits this block never looks at
  logic unused_bits;

  assign hit_txdata = (Mem_WrAddr[31:2] == BASE_ADDR[31:2]);
  assign hit_status = (Mem_WrAddr[31:2] == STATUS_ADDR[31:2]);
  assign hit        = hit_txdata | hit_status;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_FULL);

  // The serialiser only pops from IDLE, so a pop is known combinationally
  // and frees a slot for a same-cycle push into an otherwise full FIFO.
  assign pop      = (state_q == S_IDLE) && !fifo_empty;
  assign push_req = MemWrite && hit_txdata;
  assign push     = push_req && (!fifo_full || pop);

  assign baud_done  = (baud_q == BAUD_LAST);
  assign status_cnt = 8'(count_q);
  assign tx_busy    = (state_q != S_IDLE);
  assign tx         = tx_q;

  assign unused_bits = ^{Mem_WrAddr[1:0], Mem_WrData[31:8]};

  // STATUS readback; TXDATA and unmapped addresses read as zero
  always_comb begin
    ReadData = '0;
    if (hit_status) begin
      ReadData = {16'h0000, status_cnt, 4'h0, ovf_q, tx_busy, fifo_empty, fifo_full};
    end
  end

  // FIFO pointer/count next state and sticky overflow with W1C clear
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // A dropped push targets TXDATA and a clear targets STATUS, so they never coincide
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end else if (MemWrite && hit_status && Mem_WrData[3]) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO data array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= Mem_WrData[7:0];
    end
  end

  // FIFO pointers, occupancy and overflow flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Serialiser next state; tx_d is derived from the next state so tx leaves a flop
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          shift_d = fifo_mem[rd_ptr_q];
          baud_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // Serialiser registers; reset aborts any frame and returns the line high at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with a 4-clock bit time and a 4-entry FIFO.
// Inputs change #1 after a rising edge or on a falling edge; outputs are sampled on falling edges.
// Every expected value below is written out by hand from the register map and 8N1 framing.
`timescale 1ns/1ps

module tb_uart_tx_mmio;

  localparam int          CPB   = 4;
  localparam logic [31:0] TXD_A = 32'h0000_2000;
  localparam logic [31:0] STS_A = 32'h0000_2004;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] Mem_WrAddr = 32'h0;
  logic [31:0] Mem_WrData = 32'h0;
  logic [31:0] ReadData;
  logic        hit;
  logic        tx;
  logic        tx_busy;

  int n_chk = 0;
  int n_bad = 0;

  uart_tx_mmio #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (4),
    .BASE_ADDR   (32'h0000_2000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .MemWrite  (MemWrite),
    .Mem_WrAddr(Mem_WrAddr),
    .Mem_WrData(Mem_WrData),
    .ReadData  (ReadData),
    .hit       (hit),
    .tx        (tx),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  // One store; the write lands on the next rising edge, returns #1 after it
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite   = 1'b1;
    Mem_WrAddr = a;
    Mem_WrData = d;
    @(posedge clk);
    #1;
    MemWrite   = 1'b0;
    Mem_WrAddr = 32'h0;
    Mem_WrData = 32'h0;
  endtask

  // Combinational load: present an address, let it settle, compare
  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_hit);
    Mem_WrAddr = a;
    #1;
    chk({tag, "_rd"}, ReadData, exp_rd);
    chk({tag, "_hit"}, {31'h0, hit}, {31'h0, exp_hit});
    Mem_WrAddr = 32'h0;
  endtask

  // Next 10*CPB falling edges must carry start, b LSB-first, stop
  task automatic check_frame(input string tag, input logic [7:0] b);
    logic [9:0] bits;
    bits = {1'b1, b, 1'b0};
    for (int j = 0; j < 10; j++) begin
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        chk($sformatf("%s_bit%0d_c%0d_tx", tag, j, k), {31'h0, tx}, {31'h0, bits[j]});
        if (k == 0) begin
          chk($sformatf("%s_bit%0d_busy", tag, j), {31'h0, tx_busy}, 32'h1);
        end
      end
    end
  endtask

  // The single idle cycle after a frame
  task automatic gap(input string tag);
    @(negedge clk);
    chk({tag, "_tx"}, {31'h0, tx}, 32'h1);
    chk({tag, "_busy"}, {31'h0, tx_busy}, 32'h0);
  endtask

  // Bounded wait for the IDLE cycle; returns on the falling edge that sees it
  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!tx_busy) break;
    end
    chk({tag, "_idle"}, {31'h0, tx_busy}, 32'h0);
  endtask

  // Line must stay idle for n cycles
  task automatic quiet(input string tag, input int n);
    int lows;
    int busys;
    lows  = 0;
    busys = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (tx_busy !== 1'b0) busys++;
    end
    chk({tag, "_txlow"}, lows, 0);
    chk({tag, "_busy"}, busys, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset state and address decode
    repeat (3) @(negedge clk);
    chk("t1_tx", {31'h0, tx}, 32'h1);
    chk("t1_busy", {31'h0, tx_busy}, 32'h0);
    rd("t1_sts", STS_A, 32'h0000_0002, 1'b1);
    rd("t1_txd", TXD_A, 32'h0000_0000, 1'b1);
    rd("t1_off", 32'h0000_2006, 32'h0000_0002, 1'b1);
    rd("t1_miss", 32'h0000_3000, 32'h0000_0000, 1'b0);
    rd("t1_next", 32'h0000_2008, 32'h0000_0000, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // 2. Single frame 0x55; pop one edge after the store, then 40 busy cycles
    store(TXD_A, 32'h0000_0055);
    @(negedge clk);
    chk("t2_pre_tx", {31'h0, tx}, 32'h1);
    chk("t2_pre_busy", {31'h0, tx_busy}, 32'h0);
    check_frame("t2", 8'h55);
    gap("t2_end");
    rd("t2_sts", STS_A, 32'h0000_0002, 1'b1);

    // 3. Back-to-back frames with exactly one idle cycle between them
    store(TXD_A, 32'h0000_00A5);
    store(TXD_A, 32'h0000_003C);
    check_frame("t3a", 8'hA5);
    gap("t3_gap");
    check_frame("t3b", 8'h3C);
    gap("t3_end");

    // 4. Overflow while a frame is in flight, then W1C clear
    store(TXD_A, 32'h0000_0011);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 1; i <= 5; i++) store(TXD_A, i);
    rd("t4_ovf", STS_A, 32'h0000_040D, 1'b1);
    store(STS_A, 32'h0000_0008);
    rd("t4_clr", STS_A, 32'h0000_0405, 1'b1);
    wait_idle("t4_w", 200);
    check_frame("t4_01", 8'h01);
    gap("t4_g1");
    check_frame("t4_02", 8'h02);
    gap("t4_g2");
    check_frame("t4_03", 8'h03);
    gap("t4_g3");
    check_frame("t4_04", 8'h04);
    gap("t4_g4");
    quiet("t4_nofifth", 60);
    rd("t4_end", STS_A, 32'h0000_0002, 1'b1);

    // 5. Push into a full FIFO in the pop cycle is accepted
    store(TXD_A, 32'h0000_0061);
    repeat (2) @(posedge clk);
    #1;
    store(TXD_A, 32'h0000_0062);
    store(TXD_A, 32'h0000_0063);
    store(TXD_A, 32'h0000_0064);
    store(TXD_A, 32'h0000_0065);
    rd("t5_full", STS_A, 32'h0000_0405, 1'b1);
    wait_idle("t5_w", 200);
    store(TXD_A, 32'h0000_0077);
    rd("t5_pop", STS_A, 32'h0000_0405, 1'b1);
    check_frame("t5_62", 8'h62);
    gap("t5_g1");
    check_frame("t5_63", 8'h63);
    gap("t5_g2");
    check_frame("t5_64", 8'h64);
    gap("t5_g3");
    check_frame("t5_65", 8'h65);
    gap("t5_g4");
    check_frame("t5_77", 8'h77);
    gap("t5_g5");
    rd("t5_end", STS_A, 32'h0000_0002, 1'b1);

    // 6. Async reset during DATA bit 3 of 0x52 (bit 3 = 0) with 0x33 queued
    store(TXD_A, 32'h0000_0052);
    store(TXD_A, 32'h0000_0033);
    repeat (18) @(negedge clk);
    chk("t6_pre_tx", {31'h0, tx}, 32'h0);
    #1;
    reset = 1'b0;
    #1;
    chk("t6_rst_tx", {31'h0, tx}, 32'h1);
    chk("t6_rst_busy", {31'h0, tx_busy}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    rd("t6_sts", STS_A, 32'h0000_0002, 1'b1);
    quiet("t6_noresid", 60);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
